axi_slave_mem: RTL and testbench

AXI_SLAVE_MEM -- requirements
Module: axi_slave_mem

---
 rtl/axi_slave_mem.sv | 259 +++++++++++++++++++++++++
 tb/tb_axi_slave_mem.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_slave_mem.sv
// axi_slave_mem: AXI slave backed by a 2^MEM_AW x 32-bit word memory.
// Independent write and read channels, one outstanding transaction each,
// FIXED / INCR / WRAP bursts, every beat 4 bytes wide.
// Optional build macro AXI_SLAVE_MEM_ERR_EN adds DECERR / SLVERR responses;
// without it every response is OKAY and out-of-range addresses alias into
// the memory.
module axi_slave_mem #(
    parameter int MEM_AW = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] s_AWADDR,
    input  logic        s_AWVALID,
    input  logic [7:0]  s_AWLEN,
    input  logic [2:0]  s_AWSIZE,
    input  logic        s_AWID,
    input  logic [1:0]  s_AWBURST,
    output logic        s_AWREADY,
    input  logic [31:0] s_WDATA,
    input  logic        s_WVALID,
    input  logic [3:0]  s_WSTRB,
    input  logic        s_WLAST,
    output logic        s_WREADY,
    output logic        s_BVALID,
    output logic [1:0]  s_BRESP,
    output logic        s_BID,
    input  logic        s_BREADY,
    input  logic [31:0] s_ARADDR,
    input  logic        s_ARVALID,
    input  logic [7:0]  s_ARLEN,
    input  logic [2:0]  s_ARSIZE,
    input  logic        s_ARID,
    input  logic [1:0]  s_ARBURST,
    output logic        s_ARREADY,
    output logic        s_RVALID,
    output logic [31:0] s_RDATA,
    output logic        s_RLAST,
    output logic [1:0]  s_RRESP,
    output logic        s_RID,
    input  logic        s_RREADY
);

    // state    | meaning
    // W_IDLE   | AWREADY high, waiting for a write address
    // W_DATA   | WREADY high, accepting beats until len+1 are taken
    // W_RESP   | BVALID high, waiting for BREADY
    // R_IDLE   | ARREADY high, waiting for a read address
    // R_DATA   | RVALID high, one beat presented, advance on RREADY
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;
    localparam int         DEPTH       = 1 << MEM_AW;

    logic [31:0] mem [DEPTH];

    w_state_t    w_state;
    logic [31:0] w_addr;
    logic [7:0]  w_len;
    logic [1:0]  w_burst;
    logic [7:0]  w_cnt;
    logic        w_dec;
    logic        w_slv;
    logic        wr_en;

    r_state_t    r_state;
    logic [31:0] r_addr;
    logic [31:0] r_next;
    logic [7:0]  r_len;
    logic [1:0]  r_burst;
    logic [7:0]  r_cnt;
    logic        r_dec;

    logic        aw_dec;
    logic        aw_slv;
    logic        ar_dec;
    logic        ar_slv;
    logic        wlast_bad;

    // Wrap window is (len+1)*4 bytes; for the legal power-of-two lengths
    // {len, 2'b11} is exactly the in-window offset mask.
    function automatic logic [31:0] next_addr(input logic [31:0] a,
                                              input logic [7:0]  len,
                                              input logic [1:0]  burst);
        logic [31:0] mask;
        mask = {22'd0, len, 2'b11};
        case (burst)
            BURST_FIXED: next_addr = a;
            BURST_WRAP:  next_addr = (a & ~mask) | ((a + 32'd4) & mask);
            default:     next_addr = a + 32'd4;
        endcase
    endfunction

    function automatic logic [MEM_AW-1:0] word_idx(input logic [31:0] a);
        return a[MEM_AW+1:2];
    endfunction

`ifdef AXI_SLAVE_MEM_ERR_EN
    function automatic logic bad_wrap(input logic [1:0] burst, input logic [7:0] len);
        return (burst == BURST_WRAP) &&
               !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15);
    endfunction

    assign aw_dec    = |s_AWADDR[31:MEM_AW+2];
    assign aw_slv    = (s_AWSIZE != 3'd2) || bad_wrap(s_AWBURST, s_AWLEN);
    assign ar_dec    = |s_ARADDR[31:MEM_AW+2];
    assign ar_slv    = (s_ARSIZE != 3'd2) || bad_wrap(s_ARBURST, s_ARLEN);
    assign wlast_bad = s_WLAST != (w_cnt == w_len);
`else
    assign aw_dec    = 1'b0;
    assign aw_slv    = 1'b0;
    assign ar_dec    = 1'b0;
    assign ar_slv    = 1'b0;
    assign wlast_bad = 1'b0;
`endif

    // Bits that only matter when error checking is built in.
    logic unused_bits;
    assign unused_bits = ^{s_AWADDR[1:0], s_ARADDR[1:0], s_AWSIZE, s_ARSIZE, s_WLAST};

    assign r_next = next_addr(r_addr, r_len, r_burst);
    assign wr_en  = s_WREADY && s_WVALID && !w_dec;

    // Byte-lane memory write; deliberately outside reset so contents survive it.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (s_WSTRB[b]) begin
                    mem[word_idx(w_addr)][8*b +: 8] <= s_WDATA[8*b +: 8];
                end
            end
        end
    end

    // Write channel FSM with registered handshake/response outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            w_state   <= W_IDLE;
            s_AWREADY <= 1'b0;
            s_WREADY  <= 1'b0;
            s_BVALID  <= 1'b0;
            s_BRESP   <= RESP_OKAY;
            s_BID     <= 1'b0;
            w_addr    <= '0;
            w_len     <= '0;
            w_burst   <= '0;
            w_cnt     <= '0;
            w_dec     <= 1'b0;
            w_slv     <= 1'b0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (s_AWREADY && s_AWVALID) begin
                        w_addr    <= s_AWADDR;
                        w_len     <= s_AWLEN;
                        w_burst   <= s_AWBURST;
                        s_BID     <= s_AWID;
                        w_cnt     <= '0;
                        w_dec     <= aw_dec;
                        w_slv     <= aw_slv;
                        s_AWREADY <= 1'b0;
                        s_WREADY  <= 1'b1;
                        w_state   <= W_DATA;
                    end else begin
                        s_AWREADY <= 1'b1;
                    end
                end
                W_DATA: begin
                    if (s_WVALID) begin
                        w_addr <= next_addr(w_addr, w_len, w_burst);
                        w_cnt  <= w_cnt + 8'd1;
                        w_slv  <= w_slv | wlast_bad;
                        if (w_cnt == w_len) begin
                            s_WREADY <= 1'b0;
                            s_BVALID <= 1'b1;
                            if (w_dec) begin
                                s_BRESP <= RESP_DECERR;
                            end else if (w_slv || wlast_bad) begin
                                s_BRESP <= RESP_SLVERR;
                            end else begin
                                s_BRESP <= RESP_OKAY;
                            end
                            w_state <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (s_BREADY) begin
                        s_BVALID  <= 1'b0;
                        s_AWREADY <= 1'b1;
                        w_state   <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // Read channel FSM; beat data is registered at the handshake edge, so a
    // write to the same word on that edge is not yet visible.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= R_IDLE;
            s_ARREADY <= 1'b0;
            s_RVALID  <= 1'b0;
            s_RDATA   <= '0;
            s_RLAST   <= 1'b0;
            s_RRESP   <= RESP_OKAY;
            s_RID     <= 1'b0;
            r_addr    <= '0;
            r_len     <= '0;
            r_burst   <= '0;
            r_cnt     <= '0;
            r_dec     <= 1'b0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (s_ARREADY && s_ARVALID) begin
                        r_addr    <= s_ARADDR;
                        r_len     <= s_ARLEN;
                        r_burst   <= s_ARBURST;
                        r_cnt     <= '0;
                        r_dec     <= ar_dec;
                        s_RID     <= s_ARID;
                        s_RDATA   <= ar_dec ? 32'd0 : mem[word_idx(s_ARADDR)];
                        s_RLAST   <= (s_ARLEN == 8'd0);
                        s_RRESP   <= ar_dec ? RESP_DECERR : (ar_slv ? RESP_SLVERR : RESP_OKAY);
                        s_RVALID  <= 1'b1;
                        s_ARREADY <= 1'b0;
                        r_state   <= R_DATA;
                    end else begin
                        s_ARREADY <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (s_RREADY) begin
                        if (s_RLAST) begin
                            s_RVALID  <= 1'b0;
                            s_RLAST   <= 1'b0;
                            s_ARREADY <= 1'b1;
                            r_state   <= R_IDLE;
                        end else begin
                            r_addr  <= r_next;
                            r_cnt   <= r_cnt + 8'd1;
                            s_RDATA <= r_dec ? 32'd0 : mem[word_idx(r_next)];
                            s_RLAST <= (r_cnt + 8'd1 == r_len);
                        end
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_slave_mem.sv
// Directed bench for axi_slave_mem: single-beat vector table plus burst,
// stall and mid-burst reset sequences. Inputs change and outputs are
// sampled on the falling edge.
module tb_axi_slave_mem;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] s_AWADDR;
    logic        s_AWVALID;
    logic [7:0]  s_AWLEN;
    logic [2:0]  s_AWSIZE;
    logic        s_AWID;
    logic [1:0]  s_AWBURST;
    logic        s_AWREADY;
    logic [31:0] s_WDATA;
    logic        s_WVALID;
    logic [3:0]  s_WSTRB;
    logic        s_WLAST;
    logic        s_WREADY;
    logic        s_BVALID;
    logic [1:0]  s_BRESP;
    logic        s_BID;
    logic        s_BREADY;
    logic [31:0] s_ARADDR;
    logic        s_ARVALID;
    logic [7:0]  s_ARLEN;
    logic [2:0]  s_ARSIZE;
    logic        s_ARID;
    logic [1:0]  s_ARBURST;
    logic        s_ARREADY;
    logic        s_RVALID;
    logic [31:0] s_RDATA;
    logic        s_RLAST;
    logic [1:0]  s_RRESP;
    logic        s_RID;
    logic        s_RREADY;

    axi_slave_mem #(.MEM_AW(10)) dut (
        .clk(clk), .rst(rst),
        .s_AWADDR(s_AWADDR), .s_AWVALID(s_AWVALID), .s_AWLEN(s_AWLEN),
        .s_AWSIZE(s_AWSIZE), .s_AWID(s_AWID), .s_AWBURST(s_AWBURST),
        .s_AWREADY(s_AWREADY),
        .s_WDATA(s_WDATA), .s_WVALID(s_WVALID), .s_WSTRB(s_WSTRB),
        .s_WLAST(s_WLAST), .s_WREADY(s_WREADY),
        .s_BVALID(s_BVALID), .s_BRESP(s_BRESP), .s_BID(s_BID), .s_BREADY(s_BREADY),
        .s_ARADDR(s_ARADDR), .s_ARVALID(s_ARVALID), .s_ARLEN(s_ARLEN),
        .s_ARSIZE(s_ARSIZE), .s_ARID(s_ARID), .s_ARBURST(s_ARBURST),
        .s_ARREADY(s_ARREADY),
        .s_RVALID(s_RVALID), .s_RDATA(s_RDATA), .s_RLAST(s_RLAST),
        .s_RRESP(s_RRESP), .s_RID(s_RID), .s_RREADY(s_RREADY)
    );

    always #5 clk = ~clk;

    localparam logic [1:0] FIXED = 2'b00;
    localparam logic [1:0] INCR  = 2'b01;
    localparam logic [1:0] WRAP  = 2'b10;

`ifdef AXI_SLAVE_MEM_ERR_EN
    localparam logic [31:0] OOR_DATA = 32'h0000_0000;
    localparam logic [1:0]  OOR_RESP = 2'b11;
`else
    localparam logic [31:0] OOR_DATA = 32'h1234_5678;
    localparam logic [1:0]  OOR_RESP = 2'b00;
`endif

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [3:0]  strb;
        logic [31:0] data;
        logic [1:0]  resp;
    } vec_t;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] wbuf   [16];
    logic [31:0] expbuf [16];
    logic [31:0] rbuf   [16];
    logic        lbuf   [16];
    logic [1:0]  got_resp;
    logic        got_id;
    int          nbeats;
    vec_t        vecs   [11];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic sig_of(input int w);
        case (w)
            0:       return s_AWREADY;
            1:       return s_WREADY;
            2:       return s_BVALID;
            3:       return s_ARREADY;
            default: return s_RVALID;
        endcase
    endfunction

    task automatic wait_hi(input int w, input string nm);
        int n = 0;
        while (!sig_of(w) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            total++;
            bad++;
            $display("FAIL %s: timeout waiting, got 0 expected 1", nm);
        end
    endtask

    task automatic wr_burst(input logic [31:0] a, input logic [7:0] len,
                            input logic [1:0] burst, input logic id,
                            input logic [3:0] strb, input string nm);
        s_AWADDR = a; s_AWLEN = len; s_AWBURST = burst; s_AWID = id;
        s_AWSIZE = 3'd2; s_AWVALID = 1'b1;
        wait_hi(0, {nm, "_aw"});
        @(negedge clk);
        s_AWVALID = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            s_WDATA = wbuf[i]; s_WSTRB = strb; s_WLAST = (i == int'(len));
            s_WVALID = 1'b1;
            wait_hi(1, {nm, "_w"});
            @(negedge clk);
        end
        s_WVALID = 1'b0; s_WLAST = 1'b0;
        s_BREADY = 1'b1;
        wait_hi(2, {nm, "_b"});
        chk({nm, "_bresp"}, s_BRESP, 2'b00);
        chk({nm, "_bid"}, s_BID, id);
        @(negedge clk);
        s_BREADY = 1'b0;
    endtask

    // In stall mode every beat is first held for a cycle with RREADY low and
    // checked against expbuf, then accepted on the next cycle.
    task automatic rd_burst(input logic [31:0] a, input logic [7:0] len,
                            input logic [1:0] burst, input logic id,
                            input bit stall, input string nm);
        int n = 0;
        bit held = 0;
        s_ARADDR = a; s_ARLEN = len; s_ARBURST = burst; s_ARID = id;
        s_ARSIZE = 3'd2; s_ARVALID = 1'b1;
        wait_hi(3, {nm, "_ar"});
        @(negedge clk);
        s_ARVALID = 1'b0;
        nbeats = 0;
        while (nbeats <= int'(len) && n < 200) begin
            if (s_RVALID) begin
                if (stall && !held) begin
                    s_RREADY = 1'b0;
                    chk({nm, "_stall_data"}, s_RDATA, expbuf[nbeats]);
                    chk({nm, "_stall_last"}, s_RLAST, nbeats == int'(len));
                    held = 1;
                end else begin
                    s_RREADY = 1'b1;
                    rbuf[nbeats] = s_RDATA;
                    lbuf[nbeats] = s_RLAST;
                    got_resp = s_RRESP;
                    got_id = s_RID;
                    nbeats++;
                    held = 0;
                end
            end else begin
                s_RREADY = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        s_RREADY = 1'b0;
        if (n >= 200) begin
            total++;
            bad++;
            $display("FAIL %s_r: timeout, got %0d beats expected %0d", nm, nbeats, int'(len) + 1);
        end
        chk({nm, "_rvalid_after"}, s_RVALID, 1'b0);
    endtask

    task automatic chk_read(input logic [7:0] len, input logic id,
                            input logic [1:0] resp, input string nm);
        chk({nm, "_beats"}, nbeats, int'(len) + 1);
        for (int i = 0; i <= int'(len); i++) begin
            chk($sformatf("%s_data%0d", nm, i), rbuf[i], expbuf[i]);
            chk($sformatf("%s_last%0d", nm, i), lbuf[i], i == int'(len));
        end
        chk({nm, "_rresp"}, got_resp, resp);
        chk({nm, "_rid"}, got_id, id);
    endtask

    initial begin
        vecs[0]  = '{1'b1, 32'h0000_0020, 4'hF, 32'hFFFF_FFFF, 2'b00};
        vecs[1]  = '{1'b1, 32'h0000_0020, 4'h5, 32'h1122_3344, 2'b00};
        vecs[2]  = '{1'b0, 32'h0000_0020, 4'h0, 32'hFF22_FF44, 2'b00};
        vecs[3]  = '{1'b1, 32'h0000_0024, 4'hF, 32'hDEAD_BEEF, 2'b00};
        vecs[4]  = '{1'b1, 32'h0000_0024, 4'hA, 32'h0000_0000, 2'b00};
        vecs[5]  = '{1'b0, 32'h0000_0024, 4'h0, 32'h00AD_00EF, 2'b00};
        vecs[6]  = '{1'b1, 32'h0000_0000, 4'hF, 32'h1234_5678, 2'b00};
        vecs[7]  = '{1'b1, 32'h0000_0FFC, 4'hF, 32'hCAFE_F00D, 2'b00};
        vecs[8]  = '{1'b0, 32'h0000_0002, 4'h0, 32'h1234_5678, 2'b00};
        vecs[9]  = '{1'b0, 32'h0000_0FFF, 4'h0, 32'hCAFE_F00D, 2'b00};
        vecs[10] = '{1'b0, 32'h0001_0000, 4'h0, OOR_DATA,      OOR_RESP};

        rst = 1'b0;
        s_AWADDR = '0; s_AWVALID = 0; s_AWLEN = '0; s_AWSIZE = 3'd2; s_AWID = 0; s_AWBURST = INCR;
        s_WDATA = '0; s_WVALID = 0; s_WSTRB = '0; s_WLAST = 0; s_BREADY = 0;
        s_ARADDR = '0; s_ARVALID = 0; s_ARLEN = '0; s_ARSIZE = 3'd2; s_ARID = 0; s_ARBURST = INCR;
        s_RREADY = 0;

        repeat (2) @(negedge clk);
        chk("rst_awready", s_AWREADY, 0);
        chk("rst_wready", s_WREADY, 0);
        chk("rst_bvalid", s_BVALID, 0);
        chk("rst_arready", s_ARREADY, 0);
        chk("rst_rvalid", s_RVALID, 0);
        chk("rst_rlast", s_RLAST, 0);
        chk("rst_rdata", s_RDATA, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_awready", s_AWREADY, 1);
        chk("post_rst_arready", s_ARREADY, 1);

        for (int i = 0; i < 11; i++) begin
            if (vecs[i].wr) begin
                wbuf[0] = vecs[i].data;
                wr_burst(vecs[i].addr, 8'd0, INCR, i[0], vecs[i].strb, $sformatf("vec%0d", i));
            end else begin
                expbuf[0] = vecs[i].data;
                rd_burst(vecs[i].addr, 8'd0, INCR, i[0], 0, $sformatf("vec%0d", i));
                chk_read(8'd0, i[0], vecs[i].resp, $sformatf("vec%0d", i));
            end
        end

        for (int i = 0; i < 4; i++) wbuf[i] = 32'hA0 + i;
        wr_burst(32'h10, 8'd3, INCR, 1'b1, 4'hF, "incr_wr");
        for (int i = 0; i < 4; i++) expbuf[i] = 32'hA0 + i;
        rd_burst(32'h10, 8'd3, INCR, 1'b1, 0, "incr_rd");
        chk_read(8'd3, 1'b1, 2'b00, "incr_rd");

        expbuf[0] = 32'hA2; expbuf[1] = 32'hA3; expbuf[2] = 32'hA0; expbuf[3] = 32'hA1;
        rd_burst(32'h18, 8'd3, WRAP, 1'b0, 0, "wrap_rd");
        chk_read(8'd3, 1'b0, 2'b00, "wrap_rd");

        wbuf[0] = 32'h1; wbuf[1] = 32'h2; wbuf[2] = 32'h3;
        wr_burst(32'h40, 8'd2, FIXED, 1'b0, 4'hF, "fixed_wr");
        for (int i = 0; i < 3; i++) expbuf[i] = 32'h3;
        rd_burst(32'h40, 8'd2, FIXED, 1'b1, 0, "fixed_rd");
        chk_read(8'd2, 1'b1, 2'b00, "fixed_rd");

        for (int i = 0; i < 8; i++) wbuf[i] = 32'hB000_0000 + i;
        wr_burst(32'h200, 8'd7, INCR, 1'b0, 4'hF, "stall_wr");
        for (int i = 0; i < 8; i++) expbuf[i] = 32'hB000_0000 + i;
        rd_burst(32'h200, 8'd7, INCR, 1'b0, 1, "stall_rd");
        chk_read(8'd7, 1'b0, 2'b00, "stall_rd");

        // Reset lands while write beat 2 of a 4-beat burst is being offered.
        wbuf[0] = 32'h5555_5555;
        wr_burst(32'h108, 8'd0, INCR, 1'b0, 4'hF, "pre_wr");
        for (int i = 0; i < 4; i++) wbuf[i] = 32'hC0 + i;
        s_AWADDR = 32'h100; s_AWLEN = 8'd3; s_AWBURST = INCR; s_AWID = 1'b1; s_AWVALID = 1'b1;
        wait_hi(0, "abort_aw");
        @(negedge clk);
        s_AWVALID = 1'b0;
        for (int i = 0; i < 2; i++) begin
            s_WDATA = wbuf[i]; s_WSTRB = 4'hF; s_WLAST = 1'b0; s_WVALID = 1'b1;
            wait_hi(1, "abort_w");
            @(negedge clk);
        end
        s_WDATA = wbuf[2]; s_WVALID = 1'b1;
        wait_hi(1, "abort_w2");
        rst = 1'b0;
        #1;
        chk("abort_awready", s_AWREADY, 0);
        chk("abort_wready", s_WREADY, 0);
        chk("abort_bvalid", s_BVALID, 0);
        chk("abort_bid", s_BID, 0);
        chk("abort_arready", s_ARREADY, 0);
        chk("abort_rdata", s_RDATA, 0);
        chk("abort_rid", s_RID, 0);
        @(negedge clk);
        s_WVALID = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("release_awready_now", s_AWREADY, 0);
        @(negedge clk);
        chk("release_awready", s_AWREADY, 1);
        chk("release_arready", s_ARREADY, 1);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("abort_no_b%0d", i), s_BVALID, 0);
            @(negedge clk);
        end
        expbuf[0] = 32'hC0; expbuf[1] = 32'hC1;
        rd_burst(32'h100, 8'd1, INCR, 1'b1, 0, "abort_rd");
        chk_read(8'd1, 1'b1, 2'b00, "abort_rd");
        expbuf[0] = 32'h5555_5555;
        rd_burst(32'h108, 8'd0, INCR, 1'b0, 0, "abort_beat2");
        chk_read(8'd0, 1'b0, 2'b00, "abort_beat2");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
